// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control path: states, opcode
// classes, and the ALU operand/operation select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_LD_WB,
    S_ALU_WB,
    S_BRANCH,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_I_LD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_SB   = 7'b1100011;

  localparam logic [1:0] SRC_A_PC   = 2'd0;
  localparam logic [1:0] SRC_A_OLD  = 2'd1;
  localparam logic [1:0] SRC_A_RS1  = 2'd2;
  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;
  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_SUB    = 2'd1;
  localparam logic [1:0] ALU_FUNCT  = 2'd2;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef struct packed {
    logic r;
    logic i;
    logic load;
    logic store;
    logic branch;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/ctrl_opdecode.sv
// Opcode to instruction-class decode, one-hot, with an
// illegal catch-all for anything the datapath cannot run.
module ctrl_opdecode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    unique case (1'b1)
      (opcode == OP_R):    cls.r      = 1'b1;
      (opcode == OP_I):    cls.i      = 1'b1;
      (opcode == OP_I_LD): cls.load   = 1'b1;
      (opcode == OP_S):    cls.store  = 1'b1;
      (opcode == OP_SB):   cls.branch = 1'b1;
      default:             cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/write-back
// sequencing, datapath strobes and the retired-instruction counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             trap
);

  state_t    state;
  state_t    state_nx;
  op_class_t cls;

  ctrl_opdecode u_opdecode (
    .opcode (opcode),
    .cls    (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= state_nx;
      if (retire) instret <= instret + 1'b1;
    end
  end

  // Every strobe stays low while reset is held, whatever the state.
  always_comb begin
    state_nx   = state;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALU_ADD;
    retire     = 1'b0;
    trap       = 1'b0;
    if (!reset) begin
      unique case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRC_B_FOUR;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_nx = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_a = SRC_A_OLD;
          alu_src_b = SRC_B_IMM;
          unique case (1'b1)
            cls.r:      state_nx = S_EXEC_R;
            cls.i:      state_nx = S_EXEC_I;
            cls.load,
            cls.store:  state_nx = S_ADDR;
            cls.branch: state_nx = S_BRANCH;
            default:    state_nx = S_TRAP;
          endcase
        end
        S_EXEC_R: begin
          alu_src_a = SRC_A_RS1;
          alu_op    = ALU_FUNCT;
          state_nx  = S_ALU_WB;
        end
        S_EXEC_I: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_FUNCT;
          state_nx  = S_ALU_WB;
        end
        S_ADDR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          state_nx  = cls.load ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (mem_ready) state_nx = S_LD_WB;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          if (mem_ready) begin
            retire   = 1'b1;
            state_nx = S_FETCH;
          end
        end
        S_LD_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
          state_nx   = S_FETCH;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          state_nx  = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a = SRC_A_RS1;
          alu_op    = ALU_SUB;
          state_nx  = S_FETCH;
          unique case (funct3)
            F3_BEQ: begin
              pc_write = alu_zero;
              pc_src   = 1'b1;
              retire   = 1'b1;
            end
            F3_BNE: begin
              pc_write = ~alu_zero;
              pc_src   = 1'b1;
              retire   = 1'b1;
            end
            default: state_nx = S_TRAP;
          endcase
        end
        S_TRAP: trap = 1'b1;
        default: state_nx = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed cycle-by-cycle vectors for multicycle_ctrl plus
// hand sequences for trap stickiness and counter wrap.
module tb_multicycle_ctrl;

  localparam int W = 4;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic       retire;
    logic       trap;
  } outs_t;

  typedef struct {
    logic         rst;
    logic [6:0]   opc;
    logic [2:0]   f3;
    logic         z;
    logic         rdy;
    outs_t        exp;
    logic [W-1:0] cnt;
  } vec_t;

  localparam outs_t O_ZERO = '0;
  localparam outs_t O_FW   = '{mem_read:1'b1, b:2'd1, default:'0};
  localparam outs_t O_FR   = '{ir_write:1'b1, pc_write:1'b1,
                               mem_read:1'b1, b:2'd1, default:'0};
  localparam outs_t O_DEC  = '{a:2'd1, b:2'd2, default:'0};
  localparam outs_t O_EXR  = '{a:2'd2, op:2'd2, default:'0};
  localparam outs_t O_EXI  = '{a:2'd2, b:2'd2, op:2'd2, default:'0};
  localparam outs_t O_ADDR = '{a:2'd2, b:2'd2, default:'0};
  localparam outs_t O_MRD  = '{mem_read:1'b1, iord:1'b1, default:'0};
  localparam outs_t O_LWB  = '{reg_write:1'b1, mem_to_reg:1'b1,
                               retire:1'b1, default:'0};
  localparam outs_t O_MWW  = '{mem_write:1'b1, iord:1'b1, default:'0};
  localparam outs_t O_MWR  = '{mem_write:1'b1, iord:1'b1,
                               retire:1'b1, default:'0};
  localparam outs_t O_AWB  = '{reg_write:1'b1, retire:1'b1, default:'0};
  localparam outs_t O_BT   = '{pc_write:1'b1, pc_src:1'b1, a:2'd2,
                               op:2'd1, retire:1'b1, default:'0};
  localparam outs_t O_BN   = '{pc_src:1'b1, a:2'd2, op:2'd1,
                               retire:1'b1, default:'0};
  localparam outs_t O_TRAP = '{trap:1'b1, default:'0};

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] BAD = 7'h7F;

  logic         clk = 1'b0;
  logic         reset;
  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic         alu_zero;
  logic         mem_ready;
  logic         ir_write, pc_write, pc_src, mem_read, mem_write, iord;
  logic         reg_write, mem_to_reg, retire, trap;
  logic [1:0]   alu_src_a, alu_src_b, alu_op;
  logic [W-1:0] instret;
  outs_t        act;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct3     (funct3),
    .alu_zero   (alu_zero),
    .mem_ready  (mem_ready),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .retire     (retire),
    .instret    (instret),
    .trap       (trap)
  );

  assign act = {ir_write, pc_write, pc_src, mem_read, mem_write, iord,
                reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                retire, trap};

  task automatic drive(input logic r, input logic [6:0] o,
                       input logic [2:0] f, input logic z,
                       input logic y);
    @(posedge clk);
    #1;
    reset = r; opcode = o; funct3 = f; alu_zero = z; mem_ready = y;
    @(negedge clk);
  endtask

  task automatic chk_o(input string nm, input outs_t e);
    n_vec++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: strobes got %h want %h", nm, act, e);
    end
  endtask

  task automatic chk_c(input string nm, input logic [W-1:0] e);
    n_vec++;
    if (instret !== e) begin
      n_bad++;
      $display("FAIL %s: instret got %0d want %0d", nm, instret, e);
    end
  endtask

  task automatic add(input logic r, input logic [6:0] o,
                     input logic [2:0] f, input logic z, input logic y,
                     input outs_t e, input logic [W-1:0] c);
    vec_t v;
    v.rst = r; v.opc = o; v.f3 = f; v.z = z; v.rdy = y;
    v.exp = e; v.cnt = c;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; opcode = I; funct3 = 3'd0;
    alu_zero = 1'b0; mem_ready = 1'b1;

    add(1, I, 0, 0, 1, O_ZERO, 0);
    // addi: 4 cycles, zero wait
    add(0, I, 0, 0, 1, O_FR,  0);
    add(0, I, 0, 0, 1, O_DEC, 0);
    add(0, I, 0, 0, 1, O_EXI, 0);
    add(0, I, 0, 0, 1, O_AWB, 0);
    // load with two wait cycles in MEM_RD
    add(0, LD, 2, 0, 1, O_FR,   1);
    add(0, LD, 2, 0, 1, O_DEC,  1);
    add(0, LD, 2, 0, 0, O_ADDR, 1);
    add(0, LD, 2, 0, 0, O_MRD,  1);
    add(0, LD, 2, 0, 0, O_MRD,  1);
    add(0, LD, 2, 0, 1, O_MRD,  1);
    add(0, LD, 2, 0, 1, O_LWB,  1);
    // R-type with one fetch wait
    add(0, R, 0, 0, 0, O_FW,  2);
    add(0, R, 0, 0, 1, O_FR,  2);
    add(0, R, 0, 0, 1, O_DEC, 2);
    add(0, R, 0, 0, 1, O_EXR, 2);
    add(0, R, 0, 0, 1, O_AWB, 2);
    // store, zero wait
    add(0, ST, 2, 0, 1, O_FR,   3);
    add(0, ST, 2, 0, 1, O_DEC,  3);
    add(0, ST, 2, 0, 1, O_ADDR, 3);
    add(0, ST, 2, 0, 1, O_MWR,  3);
    // BEQ taken / not taken, BNE taken / not taken
    add(0, BR, 0, 1, 1, O_FR,  4);
    add(0, BR, 0, 1, 1, O_DEC, 4);
    add(0, BR, 0, 1, 1, O_BT,  4);
    add(0, BR, 0, 0, 1, O_FR,  5);
    add(0, BR, 0, 0, 1, O_DEC, 5);
    add(0, BR, 0, 0, 1, O_BN,  5);
    add(0, BR, 1, 0, 1, O_FR,  6);
    add(0, BR, 1, 0, 1, O_DEC, 6);
    add(0, BR, 1, 0, 1, O_BT,  6);
    add(0, BR, 1, 1, 1, O_FR,  7);
    add(0, BR, 1, 1, 1, O_DEC, 7);
    add(0, BR, 1, 1, 1, O_BN,  7);
    // store waiting, then reset mid-access
    add(0, ST, 2, 0, 1, O_FR,   8);
    add(0, ST, 2, 0, 1, O_DEC,  8);
    add(0, ST, 2, 0, 0, O_ADDR, 8);
    add(0, ST, 2, 0, 0, O_MWW,  8);
    add(1, ST, 2, 0, 0, O_ZERO, 8);
    add(0, ST, 2, 0, 0, O_FW,   0);
    // illegal opcode
    add(0, BAD, 0, 0, 1, O_FR,   0);
    add(0, BAD, 0, 0, 1, O_DEC,  0);
    add(0, BAD, 0, 0, 1, O_TRAP, 0);

    @(posedge clk);
    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].opc, vecs[k].f3, vecs[k].z, vecs[k].rdy);
      chk_o($sformatf("vec%0d", k), vecs[k].exp);
      chk_c($sformatf("vec%0d_cnt", k), vecs[k].cnt);
    end

    // trap is sticky and silent, whatever the inputs do
    for (int c = 0; c < 20; c++) begin
      drive(0, R, 3'(c), c[0], c[1]);
      chk_o("trap_hold", O_TRAP);
    end
    chk_c("trap_cnt", 0);
    drive(1, I, 0, 0, 1);
    chk_o("trap_reset", O_ZERO);
    drive(0, I, 0, 0, 1);
    chk_o("post_reset_fetch", O_FR);

    // unsupported branch funct3 goes to TRAP without retiring
    drive(0, BR, 3'd2, 1, 1);
    drive(0, BR, 3'd2, 1, 1);
    n_vec++;
    if (retire !== 1'b0 || pc_write !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_f3: retire=%b pc_write=%b want 0 0",
               retire, pc_write);
    end
    drive(0, BR, 3'd2, 1, 1);
    chk_o("bad_f3_trap", O_TRAP);
    chk_c("bad_f3_cnt", 0);

    // counter wrap: 15 retires reach 2^W-1, the 16th wraps to 0
    drive(1, I, 0, 0, 1);
    for (int n = 0; n < 16; n++) begin
      drive(0, I, 0, 0, 1);
      drive(0, I, 0, 0, 1);
      drive(0, I, 0, 0, 1);
      drive(0, I, 0, 0, 1);
      if (n == 14) begin
        drive(0, I, 0, 0, 0);
        chk_c("cnt_max", 4'd15);
      end
    end
    drive(0, I, 0, 0, 0);
    chk_c("cnt_wrap", 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the RV32I-subset core. Sequences fetch, decode, execute, memory and write-back for the opcode classes the datapath's immediate generator supports (R, I, I_LD, S, SB). Drives the register-file, ALU-mux, memory and PC strobes, and counts retired instructions. Sits between the instruction register and the datapath; the immediate generator decodes the same instruction word in parallel.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- alu_zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes the current read/write this cycle
- ir_write  out  1  latch instruction and old_pc
- pc_write  out  1  unconditional PC load
- pc_src  out  1  0 = ALU result (PC+4), 1 = branch-target register
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  0 = address from PC, 1 = address from ALU-out register
- reg_write  out  1  register-file write enable
- mem_to_reg  out  1  0 = ALU-out, 1 = memory data register
- alu_src_a  out  2  0 = PC, 1 = old_pc, 2 = rs1
- alu_src_b  out  2  0 = rs2, 1 = constant 4, 2 = immediate
- alu_op  out  2  0 = add, 1 = subtract (compare), 2 = funct-decoded
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  CNT_W  retired-instruction count
- trap  out  1  sticky illegal-instruction flag

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, LD_WB, ALU_WB, BRANCH, TRAP.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0. Hold until mem_ready=1; in that cycle ir_write=1, pc_write=1, pc_src=0 → DECODE.
- DECODE: alu_src_a=1, alu_src_b=2, alu_op=0 (branch target into ALU-out). Next state by opcode: 0110011→EXEC_R, 0010011→EXEC_I, 0000011/0100011→ADDR, 1100011→BRANCH, else→TRAP.
- EXEC_R: alu_src_a=2, alu_src_b=0, alu_op=2 → ALU_WB. EXEC_I: same with alu_src_b=2 → ALU_WB.
- ADDR: alu_src_a=2, alu_src_b=2, alu_op=0 → MEM_RD if opcode is load, else MEM_WR.
- MEM_RD: mem_read=1, iord=1; hold until mem_ready → LD_WB. LD_WB: reg_write=1, mem_to_reg=1, retire → FETCH.
- MEM_WR: mem_write=1, iord=1; hold until mem_ready; retire on that cycle → FETCH.
- ALU_WB: reg_write=1, mem_to_reg=0, retire → FETCH.
- BRANCH: alu_src_a=2, alu_src_b=0, alu_op=1. funct3 000 (BEQ): pc_write=alu_zero; 001 (BNE): pc_write=~alu_zero; pc_src=1; retire → FETCH. Any other funct3 → TRAP, no retire.
- TRAP: all strobes 0, trap=1; held until reset.
- Unlisted outputs are 0 in every state. Strobes are combinational from state, opcode, funct3, alu_zero and mem_ready.
- instret increments on retire; wraps modulo 2^CNT_W.

## Timing
- Reset (synchronous): state←FETCH, instret←0, trap←0. Outputs are 0 in the reset cycle; mem_read is driven by FETCH from the first cycle after reset deasserts.
- Reset mid-instruction: abandons the instruction, no retire, no further strobes. A pending memory access is dropped.
- Latency at zero wait (mem_ready always 1): R/I 4 cycles, load 5, store 4, branch 3. Each memory wait cycle adds 1.
- mem_read/mem_write and iord stay stable while waiting; a request is never withdrawn before mem_ready.
- retire asserts in the final cycle of the instruction; instret shows the new value the next cycle.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.

## Structure
- Package ctrl_pkg: state enum, opcode constants (R, I, I_LD, S, SB, shared with the immediate generator), alu_src_a/b and alu_op encodings.
- One sub-module, ctrl_opdecode: combinational opcode → class (r, i, load, store, branch, illegal).
- The top level holds the state register, output decode and instret counter.

## Test plan
- I-type addi (0x00500093), mem_ready=1 → FETCH, DECODE, EXEC_I, ALU_WB, reg_write in cycle 4, instret=1.
- Load with mem_ready low for 2 cycles in MEM_RD → mem_read and iord=1 held for 3 cycles; total 7 cycles; reg_write with mem_to_reg=1.
- BEQ with alu_zero=1 → pc_write=1, pc_src=1 in cycle 3. Same with alu_zero=0 → pc_write=0. Both cases retire.
- Opcode 0x7F → TRAP after DECODE; trap=1 sticky, no strobes for 20 cycles, instret unchanged. Reset clears it.
- Reset asserted in MEM_WR during a wait → no mem_write next cycle, state FETCH, instret=0.
- Preload instret to 2^CNT_W−1 via CNT_W=4 and 15 retires; the 16th retire → instret=0.
